// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_add_sub
// Brief   : Sliced, valid/ready pipelined adder/subtractor with flags and tag.
//           Optional macro ADDER_SAT_EN clamps the result on signed overflow.
// Revision: 1.0
// ============================================================================
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW   = WIDTH / STAGES;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;

  // Inter-stage registers; element k is the output of stage k.
  logic [WIDTH-1:0] a_q   [NREG];
  logic [WIDTH-1:0] b_q   [NREG];
  logic [WIDTH-1:0] r_q   [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic             c_q   [NREG];
  logic             v_q   [NREG];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    sa_s;
    logic [SW-1:0]    sb_s;
    logic [WIDTH-1:0] sr;
    logic [TAG_W-1:0] st;
    logic             sc;
    logic             sv;
    logic [SW:0]      ssum;
    logic [WIDTH-1:0] nr;

    if (k == 0) begin : g_first
      assign sa_s = a[k*SW +: SW];
      assign sb_s = b_eff[k*SW +: SW];
      assign sr   = '0;
      assign st   = in_tag;
      assign sc   = cin;
      assign sv   = in_valid;
    end else begin : g_mid
      assign sa_s = a_q[k-1][k*SW +: SW];
      assign sb_s = b_q[k-1][k*SW +: SW];
      assign sr   = r_q[k-1];
      assign st   = tag_q[k-1];
      assign sc   = c_q[k-1];
      assign sv   = v_q[k-1];
    end

    assign ssum = {1'b0, sa_s} + {1'b0, sb_s} + {{SW{1'b0}}, sc};

    always_comb begin
      nr              = sr;
      nr[k*SW +: SW]  = ssum[SW-1:0];
    end

    if (k < STAGES - 1) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[k] <= 1'b0;
        end else if (advance) begin
          v_q[k] <= sv;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          r_q[k]   <= nr;
          tag_q[k] <= st;
          c_q[k]   <= ssum[SW];
        end
      end

      if (k == 0) begin : g_src_in
        always_ff @(posedge clk) begin
          if (advance) begin
            a_q[k] <= a;
            b_q[k] <= b_eff;
          end
        end
      end else begin : g_src_pipe
        always_ff @(posedge clk) begin
          if (advance) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
          end
        end
      end
    end else begin : g_last
      logic             msb_cin;
      logic             raw_of;
      logic [WIDTH-1:0] res;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign msb_cin = nr[WIDTH-1] ^ sa_s[SW-1] ^ sb_s[SW-1];
      assign raw_of  = msb_cin ^ ssum[SW];

`ifdef ADDER_SAT_EN
      always_comb begin
        res = nr;
        if (raw_of) begin
          res = nr[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
      end
`else
      assign res = nr;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          of        <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
          out_tag   <= '0;
        end else if (advance) begin
          out_valid <= sv;
          sum       <= res;
          cout      <= ssum[SW];
          of        <= raw_of;
          zero      <= (res == '0);
          neg       <= res[WIDTH-1];
          out_tag   <= st;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipelined_add_sub
// Brief   : Directed vector bench for pipelined_add_sub (32-bit, 4 stages).
// Revision: 1.0
// ============================================================================
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        of;
  logic        zero;
  logic        neg;
  logic [4:0]  out_tag;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .of(of), .zero(zero), .neg(neg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [4:0]  tag;
    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_of;
    logic        e_zero;
    logic        e_neg;
  } vec_t;

  vec_t vecs [10];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_tag = v.tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_sum"},  sum,     v.e_sum);
    chk({nm, "_cout"}, cout,    v.e_cout);
    chk({nm, "_of"},   of,      v.e_of);
    chk({nm, "_zero"}, zero,    v.e_zero);
    chk({nm, "_neg"},  neg,     v.e_neg);
    chk({nm, "_tag"},  out_tag, v.tag);
    @(posedge clk);
  endtask

  initial begin
    int issued, rcv, stall_left, cyc, extra;
    logic acc;
    logic [31:0] hold_sum;
    logic [4:0]  hold_tag;

    //            a             b            cin   sub   tag    sum           cout  of    zero  neg
`ifdef ADDER_SAT_EN
    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd3,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd5,  32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 5'd9,  32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd3,  32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd5,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 5'd9,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd4,  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 5'd6,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 5'd7,  32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, 5'd8,  32'h12355678, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 5'd31, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 5'd10, 32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, of, zero, neg}, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back tags 1..8 with a 3-cycle consumer stall after the first result
    issued = 0; rcv = 0; stall_left = 0; cyc = 0;
    while (rcv < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (stall_left == 3) begin
          hold_sum = sum;
          hold_tag = out_tag;
        end else begin
          chk("stall_sum_hold", sum, hold_sum);
          chk("stall_tag_hold", out_tag, hold_tag);
        end
        stall_left--;
      end else if (out_valid) begin
        chk($sformatf("burst%0d_tag", rcv + 1), out_tag, rcv + 1);
        chk($sformatf("burst%0d_sum", rcv + 1), sum, 32'h101 * (rcv + 1));
        rcv++;
        if (rcv == 1) stall_left = 3;
      end
      if (issued < 8) begin
        in_valid = 1'b1;
        a = issued + 1;
        b = (issued + 1) << 8;
        cin = 1'b0; sub = 1'b0;
        in_tag = 5'(issued + 1);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) issued++;
      cyc++;
    end
    chk("burst_received", rcv, 8);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("burst_no_duplicate", extra, 0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0;
      in_tag = 5'(20 + i); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midrst_discarded", extra, 0);
    run_op(vecs[5], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
